// File: rtl/mac_array_gen.sv
// Layer MAC array: one activation per beat broadcast to N_MAC lanes, each with its own weight,
// bias pre-load, two-stage multiply/accumulate pipeline and sticky saturation flag.
// Optional build macro: MAC_ARRAY_RELU_EN clamps negative lane results to zero on acc_out only.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready. in_ready is high
// only in ACCUM and never depends on in_valid; pixel/weights must be stable while in_valid is high.
module mac_array_gen #(
    parameter int N_MAC      = 32,
    parameter int IN_W       = 8,
    parameter int W_W        = 8,
    parameter int B_W        = 8,
    parameter int ACC_W      = 20,
    parameter int BIAS_SHIFT = 8,
    parameter int N_IN       = 784
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        pixel,
    input  logic [N_MAC*W_W-1:0]   weights,
    input  logic [N_MAC*B_W-1:0]   biases,
    output logic                   busy,
    output logic                   done,
    output logic                   out_valid,
    output logic [N_MAC*ACC_W-1:0] acc_out,
    output logic [N_MAC-1:0]       ovf,
    output logic [2:0]             dbg_state
);
    localparam int P_W   = IN_W + W_W;
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pvld_q, pvld_d;
    logic             done_q, done_d;
    logic             beat_acc;

    assign beat_acc = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BIAS;
            S_BIAS:  state_d = S_ACCUM;
            S_ACCUM: if (beat_acc && cnt_q == LAST_BEAT) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (start) state_d = S_BIAS;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_ACCUM);
        busy      = (state_q == S_BIAS) || (state_q == S_ACCUM) || (state_q == S_DRAIN);
        out_valid = (state_q == S_DONE);
        done      = done_q;
        dbg_state = state_q;
    end

    // Beat counter stops at the last beat instead of wrapping; the FSM leaves ACCUM there.
    always_comb begin
        cnt_d  = cnt_q;
        pvld_d = beat_acc;
        done_d = (state_d == S_DONE) && (state_q != S_DONE);
        if (state_q == S_BIAS) begin
            cnt_d = '0;
        end else if (beat_acc && cnt_q != LAST_BEAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pvld_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pvld_q <= pvld_d;
            done_q <= done_d;
        end
    end

    for (genvar g = 0; g < N_MAC; g++) begin : g_lane
        logic signed [IN_W-1:0]  pix_s;
        logic signed [W_W-1:0]   wt_s;
        logic signed [P_W-1:0]   prod_q, prod_d;
        logic signed [ACC_W-1:0] acc_q, acc_d, bias_ld, acc_ro;
        logic signed [ACC_W:0]   sum;
        logic                    ovf_q, ovf_d;

        assign pix_s   = pixel;
        assign wt_s    = weights[g*W_W +: W_W];
        assign bias_ld = {{(ACC_W-B_W){biases[g*B_W+B_W-1]}}, biases[g*B_W +: B_W]} << BIAS_SHIFT;
        // One guard bit: the two top bits disagree exactly when the true sum leaves ACC_W range.
        assign sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-P_W){prod_q[P_W-1]}}, prod_q};

        always_comb begin
            prod_d = prod_q;
            acc_d  = acc_q;
            ovf_d  = ovf_q;
            if (beat_acc) begin
                prod_d = P_W'(pix_s) * P_W'(wt_s);
            end
            if (state_q == S_BIAS) begin
                acc_d = bias_ld;
                ovf_d = 1'b0;
            end else if (pvld_q) begin
                if (sum[ACC_W] != sum[ACC_W-1]) begin
                    ovf_d = 1'b1;
                    acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q <= '0;
                acc_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                prod_q <= prod_d;
                acc_q  <= acc_d;
                ovf_q  <= ovf_d;
            end
        end

`ifdef MAC_ARRAY_RELU_EN
        assign acc_ro = acc_q[ACC_W-1] ? '0 : acc_q;
`else
        assign acc_ro = acc_q;
`endif

        assign acc_out[g*ACC_W +: ACC_W] = acc_ro;
        assign ovf[g]                    = ovf_q;
    end

endmodule

// File: tb/tb_mac_array_gen.sv
// Directed bench for mac_array_gen: a default-size instance for the full-length vectors and
// a 4-lane, 4-beat, 17-bit-accumulator instance driven from a vector table.
module tb_mac_array_gen;
    localparam int BN = 32, BIN = 784, BACC = 20;
    localparam int SN = 4,  SIN = 4,   SACC = 17;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 b_start, b_in_valid, b_in_ready, b_busy, b_done, b_out_valid;
    logic [7:0]           b_pixel;
    logic [BN*8-1:0]      b_weights, b_biases;
    logic [BN*BACC-1:0]   b_acc_out;
    logic [BN-1:0]        b_ovf;
    logic [2:0]           b_state;

    logic                 s_start, s_in_valid, s_in_ready, s_busy, s_done, s_out_valid;
    logic [7:0]           s_pixel;
    logic [SN*8-1:0]      s_weights, s_biases;
    logic [SN*SACC-1:0]   s_acc_out;
    logic [SN-1:0]        s_ovf;
    logic [2:0]           s_state;

    mac_array_gen u_big (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .pixel(b_pixel), .weights(b_weights), .biases(b_biases), .busy(b_busy), .done(b_done),
        .out_valid(b_out_valid), .acc_out(b_acc_out), .ovf(b_ovf), .dbg_state(b_state)
    );

    mac_array_gen #(.N_MAC(SN), .N_IN(SIN), .ACC_W(SACC)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .pixel(s_pixel), .weights(s_weights), .biases(s_biases), .busy(s_busy), .done(s_done),
        .out_valid(s_out_valid), .acc_out(s_acc_out), .ovf(s_ovf), .dbg_state(s_state)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0][7:0]  bias;
        logic [3:0][7:0]  wt;
        logic [3:0][7:0]  pix;
        logic             gap;
        logic [7:0]       mid_start;
        logic [3:0][31:0] exp_acc;
        logic [3:0]       exp_ovf;
        logic [7:0]       exp_done;
    } vec_t;

    vec_t       tbl[4];
    logic [7:0] b_seq[BIN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MAC_ARRAY_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int b_lane(input int i);
        logic signed [BACC-1:0] v;
        v = b_acc_out[i*BACC +: BACC];
        return int'(v);
    endfunction

    function automatic int s_lane(input int i);
        logic signed [SACC-1:0] v;
        v = s_acc_out[i*SACC +: SACC];
        return int'(v);
    endfunction

    function automatic logic [3:0][7:0] p8(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][7:0] r;
        r[0] = a0[7:0]; r[1] = a1[7:0]; r[2] = a2[7:0]; r[3] = a3[7:0];
        return r;
    endfunction

    function automatic logic [3:0][31:0] p32(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0][7:0] bias, input logic [3:0][7:0] wt,
                                input logic [3:0][7:0] pix, input logic gap, input int mid,
                                input logic [3:0][31:0] exp_acc, input logic [3:0] exp_ovf,
                                input int exp_done);
        vec_t v;
        v.bias = bias; v.wt = wt; v.pix = pix; v.gap = gap; v.mid_start = mid[7:0];
        v.exp_acc = exp_acc; v.exp_ovf = exp_ovf; v.exp_done = exp_done[7:0];
        return v;
    endfunction

    // Start in cycle 0, stream b_seq, return the cycle in which done is seen (-1 on timeout).
    // abort_beat >= 0 raises rst once that many beats have been accepted and returns -2.
    task automatic big_run(input int abort_beat, input int mid_start, output int done_cyc);
        int   cyc, beat;
        logic acc;
        cyc = 0; beat = 0; done_cyc = -1;
        @(posedge clk); #1;
        b_start = 1'b1; b_in_valid = 1'b1; b_pixel = b_seq[0];
        while (cyc < 2000) begin
            @(negedge clk);
            if (b_done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == 1) check("big_bias_cycle{busy,in_ready,out_valid}",
                                {61'd0, b_busy, b_in_ready, b_out_valid}, 64'b100);
            acc = b_in_valid && b_in_ready;
            @(posedge clk); #1;
            cyc++;
            b_start = (cyc == mid_start);
            if (acc) beat++;
            if (beat == abort_beat) begin
                rst = 1'b1; b_in_valid = 1'b0; done_cyc = -2;
                return;
            end
            b_in_valid = (beat < BIN);
            if (beat < BIN) b_pixel = b_seq[beat];
        end
        b_in_valid = 1'b0; b_start = 1'b0;
        if (done_cyc >= 0) begin
            @(negedge clk);
            check("big_done_pulse_width", {63'd0, b_done}, 64'd0);
            check("big_out_valid_held", {63'd0, b_out_valid}, 64'd1);
        end
    endtask

    task automatic small_run(input vec_t v, output int done_cyc);
        int   cyc, beat, gap_left;
        logic acc;
        cyc = 0; beat = 0; gap_left = 0; done_cyc = -1;
        @(posedge clk); #1;
        s_biases = v.bias; s_weights = v.wt;
        s_start = 1'b1; s_in_valid = 1'b1; s_pixel = v.pix[0];
        while (cyc < 200) begin
            @(negedge clk);
            if (s_done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == 1) check("small_bias_cycle{busy,in_ready,out_valid}",
                                {61'd0, s_busy, s_in_ready, s_out_valid}, 64'b100);
            if (cyc == 2) check("small_accum_in_ready", {63'd0, s_in_ready}, 64'd1);
            acc = s_in_valid && s_in_ready;
            @(posedge clk); #1;
            cyc++;
            s_start = (cyc == int'(v.mid_start));
            if (acc) begin
                beat++;
                if (beat == 2 && v.gap) gap_left = 3;
            end
            if (gap_left > 0) begin
                s_in_valid = 1'b0;
                gap_left--;
            end else begin
                s_in_valid = (beat < SIN);
            end
            if (beat < SIN) s_pixel = v.pix[beat];
        end
        s_in_valid = 1'b0; s_start = 1'b0;
        if (done_cyc >= 0) begin
            @(negedge clk);
            check("small_done_pulse_width", {63'd0, s_done}, 64'd0);
            check("small_out_valid_held", {63'd0, s_out_valid}, 64'd1);
        end
    endtask

    task automatic check_big_idle(input string tag);
        check({tag, "_state"}, {61'd0, b_state}, 64'd0);
        check({tag, "_ctrl{in_ready,busy,done,out_valid}"},
              {60'd0, b_in_ready, b_busy, b_done, b_out_valid}, 64'd0);
        check({tag, "_acc_out_zero"}, {63'd0, (b_acc_out == '0)}, 64'd1);
        check({tag, "_ovf"}, {32'd0, b_ovf}, 64'd0);
    endtask

    task automatic load_test1();
        for (int i = 0; i < BN; i++) begin
            b_weights[i*8 +: 8] = 8'sd3;
            b_biases[i*8 +: 8]  = 8'sd1;
        end
        for (int k = 0; k < BIN; k++) b_seq[k] = (k == 0) ? 8'sd2 : 8'sd0;
    endtask

    task automatic check_test1(input string tag, input int done_cyc);
        check_int({tag, "_done_cycle"}, done_cyc, 787);
        for (int i = 0; i < BN; i++)
            check_int($sformatf("%s_lane%0d", tag, i), b_lane(i), relu(262));
        check({tag, "_ovf"}, {32'd0, b_ovf}, 64'd0);
    endtask

    initial begin
        int dc;

        tbl[0] = mk(p8(0, -1, 2, 0), p8(1, 2, 3, 4), p8(1, -2, 3, 4), 1'b0, 0,
                    p32(6, -244, 530, 24), 4'b0000, 7);
        tbl[1] = mk(p8(0, -1, 2, 0), p8(1, 2, 3, 4), p8(1, -2, 3, 4), 1'b1, 5,
                    p32(6, -244, 530, 24), 4'b0000, 10);
        tbl[2] = mk(p8(127, -128, 0, -1), p8(127, -128, -128, 0), p8(127, 127, 127, 127), 1'b0, 0,
                    p32(65535, -65536, -65024, -256), 4'b0011, 7);
        tbl[3] = mk(p8(0, -1, -2, 3), p8(-128, -128, 127, 0), p8(-128, -128, -128, -128), 1'b0, 6,
                    p32(65535, 65280, -65536, 768), 4'b0001, 7);

        rst = 1'b1;
        b_start = 1'b0; b_in_valid = 1'b0; b_pixel = '0; b_weights = '0; b_biases = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_pixel = '0; s_weights = '0; s_biases = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_big_idle("reset");
        check("reset_small_outputs", {s_in_ready, s_busy, s_done, s_out_valid, s_ovf, s_acc_out},
              64'd0);

        // Single non-zero beat over a full-length vector.
        load_test1();
        big_run(-1, 0, dc);
        check_test1("t1", dc);

        // Saturation in both directions next to an in-range lane; start pulsed mid-ACCUM.
        b_weights = '0; b_biases = '0;
        b_weights[0*8 +: 8] = 8'sd127;  b_biases[0*8 +: 8] = 8'sd127;
        b_weights[1*8 +: 8] = -8'sd128; b_biases[1*8 +: 8] = -8'sd128;
        b_weights[2*8 +: 8] = 8'sd1;
        for (int k = 0; k < BIN; k++) b_seq[k] = 8'sd127;
        big_run(-1, 300, dc);
        check_int("sat_done_cycle_start_ignored", dc, 787);
        check_int("sat_lane0_max", b_lane(0), relu(524287));
        check_int("sat_lane1_min", b_lane(1), relu(-524288));
        check_int("sat_lane2_inrange", b_lane(2), relu(99568));
        check_int("sat_lane3_zero", b_lane(3), 0);
        check("sat_ovf", {32'd0, b_ovf}, 64'h3);

        // Reset mid-vector, then rerun the first vector from clean.
        load_test1();
        big_run(100, 0, dc);
        check_int("abort_reached", dc, -2);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_big_idle("midreset");
        big_run(-1, 0, dc);
        check_test1("rerun", dc);

        for (int r = 0; r < 4; r++) begin
            small_run(tbl[r], dc);
            check_int($sformatf("row%0d_done_cycle", r), dc, int'(tbl[r].exp_done));
            for (int i = 0; i < SN; i++)
                check_int($sformatf("row%0d_lane%0d", r, i), s_lane(i),
                          relu($signed(tbl[r].exp_acc[i])));
            check($sformatf("row%0d_ovf", r), {60'd0, s_ovf}, {60'd0, tbl[r].exp_ovf});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
